// File: rtl/fpu_special_case_pipe_if.sv
// rtl/fpu_special_case_pipe_if.sv - operand/result handshake bundle for the FPU special-case resolver
interface fpu_special_case_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_op;
  logic [W-1:0] y_op;
  logic [W-1:0] z_op;
  logic [2:0]   op_type;
  logic [2:0]   rm;
  logic [W-1:0] normal_result;
  logic         normal_sign;
  logic         overflow;
  logic         underflow;
  logic         inexact;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic         fflags_clr;
  logic [4:0]   fflags_acc;

  modport master (
    output in_valid, x_op, y_op, z_op, op_type, rm,
    output normal_result, normal_sign, overflow, underflow, inexact,
    output out_ready, fflags_clr,
    input  in_ready, out_valid, result, flags, fflags_acc
  );

  modport slave (
    input  in_valid, x_op, y_op, z_op, op_type, rm,
    input  normal_result, normal_sign, overflow, underflow, inexact,
    input  out_ready, fflags_clr,
    output in_ready, out_valid, result, flags, fflags_acc
  );
endinterface

// File: rtl/fpu_special_case_pipe.sv
// rtl/fpu_special_case_pipe.sv - two-stage IEEE 754 special-case resolver; FPU_SC_NAN_PAYLOAD_EN enables NaN payload propagation
module fpu_special_case_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                   i_clk,
  input logic                   i_rst,
  fpu_special_case_pipe_if.slave io_bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_FMA = 3'b011;
  localparam logic [2:0] OP_FMS = 3'b100;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // class bits: [3] zero, [2] inf, [1] nan (any), [0] signalling nan
  function automatic logic [3:0] classify(input logic [W-1:0] v);
    logic exp_ones, exp_zero, man_zero;
    exp_ones = &v[W-2:MAN_W];
    exp_zero = ~|v[W-2:MAN_W];
    man_zero = ~|v[MAN_W-1:0];
    return {exp_zero & man_zero, exp_ones & man_zero, exp_ones & !man_zero,
            exp_ones & !man_zero & !v[MAN_W-1]};
  endfunction

  function automatic logic [W-1:0] make_inf(input logic s);
    return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] make_max(input logic s);
    return {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  endfunction

  logic         r_s1_valid, r_s2_valid;
  logic [3:0]   r_s1_cx, r_s1_cy;
  logic [2:0]   r_s1_cz;
  logic         r_s1_sx, r_s1_sy, r_s1_sz;
  logic [2:0]   r_s1_op, r_s1_rm;
  logic [W-1:0] r_s1_nres;
  logic         r_s1_nsign, r_s1_of, r_s1_uf, r_s1_nx;
  logic [W-1:0] r_s2_result;
  logic [4:0]   r_s2_flags;
  logic [4:0]   r_acc;

  logic         w_s2_adv, w_s1_adv, w_accept;
  logic [3:0]   w_cx, w_cy, w_cz;
  logic         w_is_fma, w_is_mul, w_is_add;
  logic         w_sy_eff, w_ps, w_sz_eff, w_prod_inf;
  logic         w_snan, w_nan, w_nv_struct, w_inf, w_inf_sign;
  logic [W-1:0] w_nan_res, w_res;
  logic [4:0]   w_flg;

  // S2 drains when empty or consumed; S1 may refill whenever it can move on
  assign w_s2_adv = !r_s2_valid || io_bus.out_ready;
  assign w_s1_adv = w_s2_adv || !r_s1_valid;
  assign w_accept = io_bus.in_valid && w_s1_adv;

  assign w_cx = classify(io_bus.x_op);
  assign w_cy = classify(io_bus.y_op);
  assign w_cz = classify(io_bus.z_op);

`ifdef FPU_SC_NAN_PAYLOAD_EN
  logic [W-1:0] w_nan_src, r_s1_nan_pl;
  // z can only be the source when x and y are not NaN, which only matters for FMA/FMS
  assign w_nan_src = w_cx[1] ? io_bus.x_op : (w_cy[1] ? io_bus.y_op : io_bus.z_op);
  // quieted copy of the first NaN operand, captured alongside the class bits
  always_ff @(posedge i_clk) begin
    if (w_accept) r_s1_nan_pl <= {w_nan_src[W-1:MAN_W], 1'b1, w_nan_src[MAN_W-2:0]};
  end
  assign w_nan_res = r_s1_nan_pl;
`else
  assign w_nan_res = QNAN;
`endif

  // stage 1: capture operand classes, signs and datapath status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= io_bus.in_valid;
      if (w_accept) begin
        r_s1_cx    <= w_cx;
        r_s1_cy    <= w_cy;
        r_s1_cz    <= w_cz[2:0];
        r_s1_sx    <= io_bus.x_op[W-1];
        r_s1_sy    <= io_bus.y_op[W-1];
        r_s1_sz    <= io_bus.z_op[W-1];
        r_s1_op    <= io_bus.op_type;
        r_s1_rm    <= io_bus.rm;
        r_s1_nres  <= io_bus.normal_result;
        r_s1_nsign <= io_bus.normal_sign;
        r_s1_of    <= io_bus.overflow;
        r_s1_uf    <= io_bus.underflow;
        r_s1_nx    <= io_bus.inexact;
      end
    end
  end

  assign w_is_fma   = (r_s1_op == OP_FMA) || (r_s1_op == OP_FMS);
  assign w_is_mul   = (r_s1_op == OP_MUL);
  assign w_is_add   = !w_is_fma && !w_is_mul;
  assign w_sy_eff   = r_s1_sy ^ (r_s1_op == OP_SUB);
  assign w_ps       = r_s1_sx ^ r_s1_sy;
  assign w_sz_eff   = r_s1_sz ^ (r_s1_op == OP_FMS);
  assign w_prod_inf = r_s1_cx[2] | r_s1_cy[2];
  assign w_snan     = r_s1_cx[0] | r_s1_cy[0] | (w_is_fma & r_s1_cz[0]);
  assign w_nan      = r_s1_cx[1] | r_s1_cy[1] | (w_is_fma & r_s1_cz[1]);
  assign w_nv_struct =
      ((w_is_mul | w_is_fma) & ((r_s1_cx[3] & r_s1_cy[2]) | (r_s1_cx[2] & r_s1_cy[3])))
    | (w_is_add & r_s1_cx[2] & r_s1_cy[2] & (r_s1_sx ^ w_sy_eff))
    | (w_is_fma & w_prod_inf & !(r_s1_cx[3] | r_s1_cy[3]) & r_s1_cz[2] & (w_ps ^ w_sz_eff));
  assign w_inf      = w_prod_inf | (w_is_fma & r_s1_cz[2]);
  // for ADD/SUB the inf term is x or effective y; otherwise the product wins over the addend
  assign w_inf_sign = w_is_add ? (r_s1_cx[2] ? r_s1_sx : w_sy_eff)
                               : (w_prod_inf ? w_ps : w_sz_eff);

  // priority resolution: invalid, NaN, inf, overflow, underflow, normal
  always_comb begin
    w_res = r_s1_nres;
    w_flg = {4'b0000, r_s1_nx};
    if (w_nv_struct) begin
      w_res = QNAN;
      w_flg = 5'b10000;
    end else if (w_nan) begin
      w_res = w_nan_res;
      w_flg = {w_snan, 4'b0000};
    end else if (w_inf) begin
      w_res = make_inf(w_inf_sign);
      w_flg = 5'b00000;
    end else if (r_s1_of) begin
      w_flg = 5'b00101;
      case (r_s1_rm)
        RM_RTZ:  w_res = make_max(r_s1_nsign);
        RM_RDN:  w_res = r_s1_nsign ? make_inf(1'b1) : make_max(1'b0);
        RM_RUP:  w_res = r_s1_nsign ? make_max(1'b1) : make_inf(1'b0);
        default: w_res = make_inf(r_s1_nsign);
      endcase
    end else if (r_s1_uf) begin
      w_res = {r_s1_nsign, {(W-1){1'b0}}};
      w_flg = 5'b00011;
    end
  end

  // stage 2: hold result/flags until the consumer takes them
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_res;
        r_s2_flags  <= w_flg;
      end
    end
  end

  // sticky flags: clear first, then OR in the flags of the op being accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) r_acc <= '0;
    else r_acc <= (io_bus.fflags_clr ? 5'b00000 : r_acc)
                | ((r_s2_valid && io_bus.out_ready) ? r_s2_flags : 5'b00000);
  end

  assign io_bus.in_ready   = w_s1_adv;
  assign io_bus.out_valid  = r_s2_valid;
  assign io_bus.result     = r_s2_result;
  assign io_bus.flags      = r_s2_flags;
  assign io_bus.fflags_acc = r_acc;
endmodule
